// File: rtl/raw_fwd_buffer.sv
// raw_fwd_buffer: DEPTH-entry RAW hazard record FIFO that replays each
// record's read burst in DDR wrap order, flagging beats that hit the write.
// Ports: clk, n_rst (async low); capture side raw, burst_size_pop,
// raddr_pop, pool_waddr, pool_wdata, in_ready; replay side fwd_valid,
// fwd_ready, fwd_addr, fwd_hit, fwd_data, fwd_last; count of queued records.
// Optional macro RAW_BUF_OVERFLOW_EN adds sticky ovf (dropped capture seen).
module raw_fwd_buffer #(
    parameter int ADDR_SIZE = 8,
    parameter int DATA_SIZE = 64,
    parameter int DEPTH     = 4
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic                         raw,
    input  logic [1:0]                   burst_size_pop,
    input  logic [ADDR_SIZE-1:0]         raddr_pop,
    input  logic [ADDR_SIZE-1:0]         pool_waddr,
    input  logic [DATA_SIZE-1:0]         pool_wdata,
    output logic                         in_ready,
    output logic                         fwd_valid,
    input  logic                         fwd_ready,
    output logic [ADDR_SIZE-1:0]         fwd_addr,
    output logic                         fwd_hit,
    output logic [DATA_SIZE-1:0]         fwd_data,
    output logic                         fwd_last,
    output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef RAW_BUF_OVERFLOW_EN
    ,
    output logic                         ovf
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {IDLE, PLAY} state_t;

    typedef struct packed {
        logic [1:0]           code;
        logic [ADDR_SIZE-1:0] raddr;
        logic [ADDR_SIZE-1:0] waddr;
        logic [DATA_SIZE-1:0] wdata;
    } rec_t;

    rec_t                 mem [DEPTH];
    rec_t                 head;
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [CW-1:0]        cnt;
    logic [2:0]           beat;
    logic [2:0]           beat_max;
    state_t               state;
    state_t               state_nxt;
    logic                 push;
    logic                 adv;
    logic                 pop;
    logic                 last;
    logic [ADDR_SIZE-1:0] mask;
    logic [ADDR_SIZE-1:0] addr;

    assign head     = mem[rd_ptr];
    assign in_ready = (cnt != CW'(DEPTH));
    assign push     = raw && in_ready;
    assign adv      = (state == PLAY) && fwd_ready;
    assign pop      = adv && last;

    always_comb begin
        beat_max = 3'd0;
        unique case (head.code)
            2'd0: beat_max = 3'd0;
            2'd1: beat_max = 3'd1;
            2'd2: beat_max = 3'd3;
            2'd3: beat_max = 3'd7;
        endcase
    end

    // Low bits advance modulo the burst length; the mask keeps the
    // carry from ever reaching the block-select bits.
    assign mask = ADDR_SIZE'(beat_max);
    assign addr = (head.raddr & ~mask)
                | ((head.raddr + ADDR_SIZE'(beat)) & mask);
    assign last = (beat == beat_max);

    assign fwd_valid = (state == PLAY);
    assign fwd_addr  = fwd_valid ? addr : '0;
    assign fwd_hit   = fwd_valid && (addr == head.waddr);
    assign fwd_data  = fwd_hit ? head.wdata : '0;
    assign fwd_last  = fwd_valid && last;
    assign count     = cnt;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (push) state_nxt = PLAY;
            PLAY: if (pop && !push && cnt == CW'(1)) state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{code:  burst_size_pop,
                             raddr: raddr_pop,
                             waddr: pool_waddr,
                             wdata: pool_wdata};
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            beat   <= '0;
        end else begin
            state <= state_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      cnt <= cnt + 1'b1;
            else if (pop && !push) cnt <= cnt - 1'b1;
            if (pop)      beat <= '0;
            else if (adv) beat <= beat + 3'd1;
        end
    end

`ifdef RAW_BUF_OVERFLOW_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)               ovf <= 1'b0;
        else if (raw && !in_ready) ovf <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_raw_fwd_buffer.sv
// tb_raw_fwd_buffer: directed and random stimulus for raw_fwd_buffer,
// checked against a queue-based model of the record FIFO.
module tb_raw_fwd_buffer;

    localparam int AW    = 8;
    localparam int DW    = 64;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          raw = 1'b0;
    logic [1:0]    burst_size_pop = '0;
    logic [AW-1:0] raddr_pop = '0;
    logic [AW-1:0] pool_waddr = '0;
    logic [DW-1:0] pool_wdata = '0;
    logic          in_ready;
    logic          fwd_valid;
    logic          fwd_ready = 1'b0;
    logic [AW-1:0] fwd_addr;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;
    logic          fwd_last;
    logic [CW-1:0] count;
`ifdef RAW_BUF_OVERFLOW_EN
    logic          ovf;
`endif

    raw_fwd_buffer #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .n_rst(n_rst), .raw(raw),
        .burst_size_pop(burst_size_pop), .raddr_pop(raddr_pop),
        .pool_waddr(pool_waddr), .pool_wdata(pool_wdata),
        .in_ready(in_ready), .fwd_valid(fwd_valid),
        .fwd_ready(fwd_ready), .fwd_addr(fwd_addr),
        .fwd_hit(fwd_hit), .fwd_data(fwd_data),
        .fwd_last(fwd_last), .count(count)
`ifdef RAW_BUF_OVERFLOW_EN
        , .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          code;
        int          raddr;
        int          waddr;
        logic [63:0] wdata;
    } rec_t;

    rec_t q[$];
    int   mbeat = 0;
    bit   movf = 1'b0;
    int   n_pass = 0;
    int   n_chk = 0;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic int nbeats();
        return 1 << q[0].code;
    endfunction

    // Wrap-burst address: stay in the aligned block of nbeats addresses.
    function automatic int exp_addr();
        int nb  = nbeats();
        int off = q[0].raddr % nb;
        return q[0].raddr - off + ((off + mbeat) % nb);
    endfunction

    task automatic compare();
        int a;
        bit h;
        if (q.size() == 0) begin
            check("valid", 64'(fwd_valid), 64'd0);
            check("addr0", 64'(fwd_addr), 64'd0);
            check("hit0", 64'(fwd_hit), 64'd0);
            check("data0", fwd_data, 64'd0);
            check("last0", 64'(fwd_last), 64'd0);
        end else begin
            a = exp_addr();
            h = (a == q[0].waddr);
            check("valid", 64'(fwd_valid), 64'd1);
            check("addr", 64'(fwd_addr), 64'(a));
            check("hit", 64'(fwd_hit), 64'(h));
            check("data", fwd_data, h ? q[0].wdata : 64'd0);
            check("last", 64'(fwd_last), 64'(mbeat == nbeats() - 1));
        end
        check("count", 64'(count), 64'(q.size()));
        check("in_ready", 64'(in_ready), 64'(q.size() != DEPTH));
`ifdef RAW_BUF_OVERFLOW_EN
        check("ovf", 64'(ovf), 64'(movf));
`endif
    endtask

    // Called at a negedge: drive inputs, advance the model over the next
    // rising edge, then compare at the following negedge.
    task automatic step(bit r, int code, int ra, int wa,
                        logic [63:0] wd, bit rdy);
        bit full;
        rec_t rec;
        raw            = r;
        burst_size_pop = 2'(code);
        raddr_pop      = AW'(ra);
        pool_waddr     = AW'(wa);
        pool_wdata     = wd;
        fwd_ready      = rdy;
        full = (q.size() == DEPTH);
        if (r && full) movf = 1'b1;
        if (q.size() > 0 && rdy) begin
            if (mbeat == nbeats() - 1) begin
                void'(q.pop_front());
                mbeat = 0;
            end else begin
                mbeat++;
            end
        end
        if (r && !full) begin
            rec.code = code; rec.raddr = ra;
            rec.waddr = wa;  rec.wdata = wd;
            q.push_back(rec);
        end
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic idle(bit rdy);
        step(0, 0, 0, 0, 64'd0, rdy);
    endtask

    int          wrap_a[8] = '{5, 6, 7, 0, 1, 2, 3, 4};
    int          high_a[8] = '{8'he7, 8'he0, 8'he1, 8'he2,
                               8'he3, 8'he4, 8'he5, 8'he6};
    logic [AW-1:0] held;

    initial begin
        #1;
        compare();
        @(negedge clk);
        n_rst = 1'b1;

        // single-beat hit
        step(1, 0, 8'h9e, 8'h9e, 64'haddb6f04fefee338, 1);
        check("sb_addr", 64'(fwd_addr), 64'h9e);
        check("sb_hit", 64'(fwd_hit), 64'd1);
        check("sb_data", fwd_data, 64'haddb6f04fefee338);
        check("sb_last", 64'(fwd_last), 64'd1);
        idle(1);

        // wrap order in low block
        step(1, 3, 8'h05, 8'h00, 64'h1111, 1);
        for (int k = 0; k < 8; k++) begin
            check("wrap_addr", 64'(fwd_addr), 64'(wrap_a[k]));
            check("wrap_hit", 64'(fwd_hit), 64'(k == 3));
            check("wrap_last", 64'(fwd_last), 64'(k == 7));
            idle(1);
        end

        // high-block wrap
        step(1, 3, 8'he7, 8'he4, 64'h2222, 1);
        for (int k = 0; k < 8; k++) begin
            check("high_addr", 64'(fwd_addr), 64'(high_a[k]));
            check("high_hit", 64'(fwd_hit), 64'(k == 5));
            idle(1);
        end
        step(1, 3, 8'hf8, 8'hf9, 64'h3333, 1);
        for (int k = 0; k < 8; k++) begin
            check("f8_hit", 64'(fwd_hit), 64'(k == 1));
            idle(1);
        end

        // backpressure, full FIFO, dropped capture
        for (int i = 0; i < DEPTH; i++)
            step(1, 1 + i % 2, $urandom_range(255),
                 $urandom_range(255), {$urandom, $urandom}, 0);
        held = fwd_addr;
        for (int i = 0; i < 5; i++) begin
            idle(0);
            check("bp_count", 64'(count), 64'(DEPTH));
            check("bp_ready", 64'(in_ready), 64'd0);
            check("bp_stable", 64'(fwd_addr), 64'(held));
        end
        step(1, 0, 8'h42, 8'h42, 64'hdead, 0);
        check("drop_count", 64'(count), 64'(DEPTH));
        for (int i = 0; i < 64 && q.size() > 0; i++) idle(1);
        check("drained", 64'(count), 64'd0);

        // push on last-beat pop with one record queued
        step(1, 0, 8'h30, 8'h31, 64'h4444, 1);
        step(1, 1, 8'h51, 8'h50, 64'h5555, 1);
        check("sim_count", 64'(count), 64'd1);
        check("sim_addr", 64'(fwd_addr), 64'h51);
        check("sim_valid", 64'(fwd_valid), 64'd1);
        idle(1);
        idle(1);

        // reset mid-burst
        step(1, 2, 8'h10, 8'h12, 64'h6666, 1);
        idle(1);
        idle(1);
        check("rst_beat2", 64'(fwd_addr), 64'h12);
        n_rst = 1'b0;
        #1;
        check("rst_valid", 64'(fwd_valid), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_inrdy", 64'(in_ready), 64'd1);
        q.delete();
        mbeat = 0;
        movf = 1'b0;
        raw = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        for (int i = 0; i < 4; i++) idle(1);

        // random traffic
        for (int i = 0; i < 400; i++)
            step($urandom_range(1), $urandom_range(3),
                 $urandom_range(255), $urandom_range(255),
                 {$urandom, $urandom}, $urandom_range(2) != 0);
        for (int i = 0; i < 64 && q.size() > 0; i++) idle(1);
        check("final_count", 64'(count), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
